// File: rtl/fifo_demo_pkg.sv
// Shared definitions for the FIFO demo: drain FSM encoding, default widths
// and the fixed test words used by the write-side driver and the LED drain.
package fifo_demo_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        POP     = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } drain_state_t;

    localparam int DATA_W_DEF = 4;
    localparam int CNT_1SEC   = 125000000;

    localparam logic [3:0] PAT_A = 4'b1001;
    localparam logic [3:0] PAT_B = 4'b1110;

endpackage

// File: rtl/fifo_led_drain_hold_timer.sv
// Hold-window timer: cleared by load, counts while run is high, and raises
// done on the last cycle of a HOLD_CYCLES-long window.
module fifo_led_drain_hold_timer #(
    parameter int HOLD_CYCLES = 125000000,
    parameter int CNT_W       = 27
) (
    input  logic CLK,
    input  logic srst,
    input  logic load,
    input  logic run,
    output logic done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign done = run && (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK) begin
        if (srst || load) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= done ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_led_drain.sv
// Empty-aware FIFO drain: pops one word, latches it onto the LEDs and holds
// it for HOLD_CYCLES before the next pop. All outputs are registered.
module fifo_led_drain
    import fifo_demo_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int HOLD_CYCLES = CNT_1SEC,
    parameter int CNT_W       = 27
) (
    input  logic              CLK,
    input  logic              srst,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] led_data,
    output logic              led_valid,
    output logic [7:0]        word_count
);

    drain_state_t state;
    drain_state_t state_nxt;
    logic         hold_done;

    fifo_led_drain_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_hold_timer (
        .CLK  (CLK),
        .srst (srst),
        .load (state == CAPTURE),
        .run  (state == HOLD),
        .done (hold_done)
    );

    // NOTE: next-state is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable && !fifo_empty) state_nxt = POP;
            POP:     state_nxt = CAPTURE;
            CAPTURE: state_nxt = HOLD;
            HOLD:    if (hold_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (srst) begin
            state      <= IDLE;
            fifo_rd_en <= 1'b0;
            led_data   <= '0;
            led_valid  <= 1'b0;
            word_count <= 8'd0;
        end else begin
            state      <= state_nxt;
            // Strobe is high exactly while the FSM sits in POP.
            fifo_rd_en <= (state_nxt == POP);
            if (state == CAPTURE) begin
                led_data   <= fifo_dout;
                led_valid  <= 1'b1;
                word_count <= word_count + 8'd1;
            end else if (state == HOLD && hold_done) begin
                led_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_led_drain.sv
// Bench for fifo_led_drain: queue-based FIFO with 1-cycle read latency and a
// timeline reference model (cycles since pop) checked every clock.
module tb_fifo_led_drain;
    import fifo_demo_pkg::*;

    localparam int DW = 4;
    localparam int HC = 4;
    localparam int CW = 27;

    logic          CLK = 1'b0;
    logic          srst;
    logic          enable;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd_en;
    logic [DW-1:0] led_data;
    logic          led_valid;
    logic [7:0]    word_count;

    always #5 CLK = ~CLK;

    fifo_led_drain #(
        .DATA_W      (DW),
        .HOLD_CYCLES (HC),
        .CNT_W       (CW)
    ) dut (
        .CLK        (CLK),
        .srst       (srst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .led_data   (led_data),
        .led_valid  (led_valid),
        .word_count (word_count)
    );

    logic [DW-1:0] fq[$];
    int            rd_cycles[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;

    // Reference: age = cycles since the pop edge, -1 when free to pop.
    int            age     = -1;
    logic [DW-1:0] m_word  = '0;
    logic [DW-1:0] m_led   = '0;
    logic          m_valid = 1'b0;
    logic [7:0]    m_count = 8'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic tick();
        logic rd_s, en_s, emp_s, rst_s;
        rd_s  = fifo_rd_en;
        en_s  = enable;
        emp_s = fifo_empty;
        rst_s = srst;
        if (rst_s) begin
            age = -1; m_led = '0; m_valid = 1'b0; m_count = 8'd0;
        end else if (age < 0) begin
            if (en_s && !emp_s) begin
                age    = 0;
                m_word = fq[0];
            end
        end else begin
            age++;
            if (age == 2) begin
                m_led   = m_word;
                m_valid = 1'b1;
                m_count = m_count + 8'd1;
            end
            if (age == 2 + HC) begin
                m_valid = 1'b0;
                age     = -1;
            end
        end
        @(posedge CLK);
        #1;
        cyc++;
        if (rd_s) begin
            check("underflow", 32'(fq.size() != 0), 32'd1);
            if (fq.size() != 0) fifo_dout = fq.pop_front();
            rd_cycles.push_back(cyc);
        end
        fifo_empty = (fq.size() == 0);
        check("rd_en",      32'(fifo_rd_en), 32'(age == 0));
        check("led_data",   32'(led_data),   32'(m_led));
        check("led_valid",  32'(led_valid),  32'(m_valid));
        check("word_count", 32'(word_count), 32'(m_count));
    endtask

    initial begin
        int base, vcnt;
        srst = 1'b1; enable = 1'b0; fifo_empty = 1'b1; fifo_dout = '0;
        repeat (2) tick();
        srst = 1'b0;
        tick();

        // Single word: one strobe, 4-cycle hold.
        base = rd_cycles.size(); vcnt = 0;
        push(PAT_A); enable = 1'b1;
        repeat (12) begin tick(); if (led_valid) vcnt++; end
        check("t2_pulses", 32'(rd_cycles.size() - base), 32'd1);
        check("t2_valid_len", 32'(vcnt), 32'(HC));
        check("t2_led", 32'(led_data), 32'h9);
        check("t2_count", 32'(word_count), 32'd1);

        // Two words back to back: spacing HOLD+3.
        base = rd_cycles.size();
        push(PAT_A); push(PAT_B);
        repeat (20) tick();
        check("t3_pulses", 32'(rd_cycles.size() - base), 32'd2);
        if (rd_cycles.size() - base == 2)
            check("t3_spacing", 32'(rd_cycles[base+1] - rd_cycles[base]), 32'(HC + 3));
        check("t3_led", 32'(led_data), 32'hE);
        check("t3_count", 32'(word_count), 32'd3);
        check("t3_empty", 32'(fifo_empty), 32'd1);

        // Empty FIFO with enable held.
        base = rd_cycles.size(); vcnt = 0;
        repeat (50) begin tick(); if (led_valid) vcnt++; end
        check("t4_pulses", 32'(rd_cycles.size() - base), 32'd0);
        check("t4_valid", 32'(vcnt), 32'd0);

        // Drop enable during the first word's hold.
        base = rd_cycles.size(); vcnt = 0;
        push(PAT_A); push(PAT_B);
        for (int i = 0; i < 10 && !led_valid; i++) tick();
        check("t5_wait_valid", 32'(led_valid), 32'd1);
        enable = 1'b0;
        vcnt = 1;
        repeat (15) begin tick(); if (led_valid) vcnt++; end
        check("t5_valid_len", 32'(vcnt), 32'(HC));
        check("t5_pulses_off", 32'(rd_cycles.size() - base), 32'd1);
        enable = 1'b1;
        tick();
        check("t5_repop", 32'(fifo_rd_en), 32'd1);
        repeat (10) tick();

        // Reset mid-hold.
        push(PAT_A);
        for (int i = 0; i < 10 && !led_valid; i++) tick();
        check("t1_wait_valid", 32'(led_valid), 32'd1);
        srst = 1'b1;
        repeat (3) tick();
        srst = 1'b0;
        check("t1_rd_en", 32'(fifo_rd_en), 32'd0);
        check("t1_led", 32'(led_data), 32'd0);
        check("t1_valid", 32'(led_valid), 32'd0);
        check("t1_count", 32'(word_count), 32'd0);
        enable = 1'b0;
        tick();

        // Reset while a popped word is in CAPTURE.
        push(PAT_B); enable = 1'b1;
        for (int i = 0; i < 10 && age != 1; i++) tick();
        check("t6_in_capture", 32'(age), 32'd1);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        check("t6_count", 32'(word_count), 32'd0);
        check("t6_valid", 32'(led_valid), 32'd0);
        check("t6_led", 32'(led_data), 32'd0);
        push(PAT_A);
        for (int i = 0; i < 10 && !led_valid; i++) tick();
        check("t6_led_after", 32'(led_data), 32'h9);
        check("t6_count_after", 32'(word_count), 32'd1);

        // Randomised traffic against the reference.
        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(0, 3) != 0);
            srst   = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0 && fq.size() < 8)
                push(DW'($urandom_range(0, 15)));
            tick();
        end
        srst = 1'b0; enable = 1'b1;
        repeat (80) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
